// File: rtl/operand_link_pkg.sv
// Shared definitions for the byte-serial operand link, used by both the
// host-side transmitter and the receiver-side deserializer.
package operand_link_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2
  } link_state_t;

  localparam int BYTE_W        = 8;
  localparam int REG_WIDTH_DEF = 128;
  localparam int NBYTES        = REG_WIDTH_DEF / BYTE_W;

  // Byte k of a frame in transmission order (k = 0 is the most significant byte).
  function automatic logic [BYTE_W-1:0] frame_byte(
    input logic [REG_WIDTH_DEF-1:0] frame,
    input int                       k
  );
    frame_byte = frame[REG_WIDTH_DEF-1-k*BYTE_W -: BYTE_W];
  endfunction

endpackage

// File: rtl/operand_byte_tx_ack_timer.sv
// Saturating wait counter for the frame-consumed acknowledge; expired is
// high once the count has reached TIMEOUT-1.
module ack_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int                TMR_W = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_W-1:0]  LIMIT = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] count;

  // Holding at LIMIT instead of wrapping keeps expired stable until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/operand_byte_tx.sv
// Host-side transmitter: takes one REG_WIDTH-bit operand frame and sends it
// MSB byte first on contiguous cycles, then waits for the receiver's ack.
module operand_byte_tx
  import operand_link_pkg::*;
#(
  parameter int REG_WIDTH = 128,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [REG_WIDTH-1:0] op_data,
  output logic [BYTE_W-1:0]    byte_out,
  output logic                 byte_valid,
  output logic                 frame_start,
  input  logic                 ack_in,
  output logic                 frame_done,
  output logic                 tx_err
);

  localparam int               FRAME_BYTES = REG_WIDTH / BYTE_W;
  localparam int               CNT_W       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(FRAME_BYTES - 1);

  link_state_t          state;
  logic [CNT_W-1:0]     byte_cnt;
  logic [REG_WIDTH-1:0] shift_reg;
  logic                 timer_expired;

  assign op_ready = (state == IDLE);

  ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_ack_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state != WAIT_ACK),
    .enable  (state == WAIT_ACK),
    .expired (timer_expired)
  );

  // The first byte goes straight from op_data to byte_out on acceptance, so
  // shift_reg only ever holds the bytes still to be sent, left-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      shift_reg   <= '0;
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            shift_reg   <= {op_data[REG_WIDTH-BYTE_W-1:0], {BYTE_W{1'b0}}};
            byte_out    <= op_data[REG_WIDTH-1 -: BYTE_W];
            byte_valid  <= 1'b1;
            frame_start <= 1'b1;
            byte_cnt    <= '0;
            tx_err      <= 1'b0;
            state       <= SEND;
          end
        end
        SEND: begin
          if (byte_cnt == LAST_CNT) begin
            byte_out   <= '0;
            byte_valid <= 1'b0;
            byte_cnt   <= '0;
            state      <= WAIT_ACK;
          end else begin
            byte_out  <= shift_reg[REG_WIDTH-1 -: BYTE_W];
            shift_reg <= {shift_reg[REG_WIDTH-BYTE_W-1:0], {BYTE_W{1'b0}}};
            byte_cnt  <= byte_cnt + 1'b1;
          end
        end
        WAIT_ACK: begin
          // An ack arriving on the expiry cycle still counts as success.
          if (ack_in) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end else if (timer_expired) begin
            tx_err <= 1'b1;
            state  <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_byte_tx.sv
// Scoreboard bench for operand_byte_tx: frames push their expected bytes,
// a negedge monitor pops and compares every presented byte.
module tb_operand_byte_tx;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         op_valid;
  logic         op_ready;
  logic [127:0] op_data;
  logic [7:0]   byte_out;
  logic         byte_valid;
  logic         frame_start;
  logic         ack_in;
  logic         frame_done;
  logic         tx_err;

  localparam logic [127:0] FRAME_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] FRAME_B = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] FRAME_C = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
  localparam logic [127:0] FRAME_D = 128'hFFEEDDCC_BBAA9988_77665544_33221100;

  typedef struct packed {
    logic       first;
    logic [7:0] data;
  } exp_byte_t;

  exp_byte_t    exp_q[$];
  int           compared   = 0;
  int           mismatched = 0;
  logic [127:0] rx_word    = '0;

  always #5 clk = ~clk;

  operand_byte_tx #(
    .REG_WIDTH (128),
    .TIMEOUT   (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_data     (op_data),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .frame_start (frame_start),
    .ack_in      (ack_in),
    .frame_done  (frame_done),
    .tx_err      (tx_err)
  );

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Left-shifting receiver model plus byte-by-byte scoreboard comparison.
  always @(negedge clk) begin : monitor
    exp_byte_t e;
    if (rst_n === 1'b1 && byte_valid === 1'b1) begin
      rx_word = {rx_word[119:0], byte_out};
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_byte: got 0x%0h with no byte expected", byte_out);
      end else begin
        e = exp_q.pop_front();
        checkOutput("byte_out", {120'h0, byte_out}, {120'h0, e.data});
        checkOutput("frame_start", {127'h0, frame_start}, {127'h0, e.first});
      end
    end
  end

  task automatic applyStimulus(input logic [127:0] data);
    int        waited;
    exp_byte_t e;
    waited = 0;
    while (op_ready !== 1'b1 && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (op_ready !== 1'b1) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL op_ready_wait: got %b, expected 1", op_ready);
    end
    op_valid = 1'b1;
    op_data  = data;
    for (int k = 0; k < 16; k++) begin
      e.first = (k == 0);
      e.data  = data[127-8*k -: 8];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  // Runs out the remaining SEND cycles, then acks after 'delay' WAIT_ACK cycles.
  task automatic completeFrame(input int remaining, input int delay);
    repeat (remaining) @(posedge clk);
    #1;
    checkOutput("wait_byte_valid", {127'h0, byte_valid}, 128'h0);
    checkOutput("wait_op_ready", {127'h0, op_ready}, 128'h0);
    checkOutput("wait_frame_done", {127'h0, frame_done}, 128'h0);
    repeat (delay) begin
      @(posedge clk);
      #1;
    end
    ack_in = 1'b1;
    @(posedge clk);
    #1;
    ack_in = 1'b0;
    @(negedge clk);
    checkOutput("frame_done", {127'h0, frame_done}, 128'h1);
    checkOutput("done_op_ready", {127'h0, op_ready}, 128'h1);
    checkOutput("done_tx_err", {127'h0, tx_err}, 128'h0);
    @(negedge clk);
    checkOutput("frame_done_pulse", {127'h0, frame_done}, 128'h0);
    checkOutput("queue_drained", 128'(exp_q.size()), 128'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    op_valid = 1'b0;
    ack_in   = 1'b0;
    op_data  = '0;
    #12;
    checkOutput("reset_op_ready", {127'h0, op_ready}, 128'h1);
    checkOutput("reset_byte_valid", {127'h0, byte_valid}, 128'h0);
    checkOutput("reset_byte_out", {120'h0, byte_out}, 128'h0);
    checkOutput("reset_frame_start", {127'h0, frame_start}, 128'h0);
    checkOutput("reset_frame_done", {127'h0, frame_done}, 128'h0);
    checkOutput("reset_tx_err", {127'h0, tx_err}, 128'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] single frame with ack three cycles after last byte");
    applyStimulus(FRAME_A);
    completeFrame(16, 2);
    checkOutput("loopback_word", rx_word, FRAME_A);
    checkOutput("loopback_I1", {96'h0, rx_word[31:0]}, 128'hCCDDEEFF);
    checkOutput("loopback_I4", {96'h0, rx_word[127:96]}, 128'h00112233);

    $display("[TB] back-to-back frame with immediate ack");
    applyStimulus(FRAME_B);
    completeFrame(16, 0);
    checkOutput("loopback_b2b", rx_word, FRAME_B);

    $display("[TB] ack timeout");
    applyStimulus(FRAME_C);
    repeat (16 + 63) @(posedge clk);
    #1;
    checkOutput("tx_err_before_expiry", {127'h0, tx_err}, 128'h0);
    checkOutput("op_ready_before_expiry", {127'h0, op_ready}, 128'h0);
    @(posedge clk);
    #1;
    checkOutput("tx_err_at_expiry", {127'h0, tx_err}, 128'h1);
    checkOutput("timeout_frame_done", {127'h0, frame_done}, 128'h0);
    checkOutput("timeout_op_ready", {127'h0, op_ready}, 128'h1);
    @(posedge clk);
    #1;
    checkOutput("tx_err_sticky", {127'h0, tx_err}, 128'h1);
    applyStimulus(FRAME_D);
    checkOutput("tx_err_cleared", {127'h0, tx_err}, 128'h0);
    completeFrame(16, 1);

    $display("[TB] ack coinciding with timer expiry");
    applyStimulus(FRAME_A);
    completeFrame(16, 63);

    $display("[TB] busy protection during SEND");
    applyStimulus(FRAME_B);
    for (int i = 0; i < 16; i++) begin
      op_valid = 1'b1;
      op_data  = {4{32'hDEAD0000 + 32'(i)}};
      ack_in   = (i == 4);
      @(posedge clk);
      #1;
    end
    op_valid = 1'b0;
    ack_in   = 1'b0;
    op_data  = '0;
    completeFrame(0, 2);
    checkOutput("loopback_busy", rx_word, FRAME_B);

    $display("[TB] reset in the middle of a frame");
    applyStimulus(FRAME_C);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_byte_valid", {127'h0, byte_valid}, 128'h0);
    checkOutput("midreset_byte_out", {120'h0, byte_out}, 128'h0);
    checkOutput("midreset_op_ready", {127'h0, op_ready}, 128'h1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("inreset_byte_valid", {127'h0, byte_valid}, 128'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postreset_op_ready", {127'h0, op_ready}, 128'h1);
    checkOutput("postreset_byte_valid", {127'h0, byte_valid}, 128'h0);
    applyStimulus(FRAME_D);
    completeFrame(16, 0);
    checkOutput("loopback_after_reset", rx_word, FRAME_D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
